// File: rtl/tawas_dbus_arb_pkg.sv
// Shared definitions for the tawas data-bus arbiter: default memory latency
// and the port S request packing {WR, MASK, ADDR, WDATA}.
package tawas_dbus_arb_pkg;

   localparam int DBUS_MEM_LAT = 1;
   localparam int SREQ_W       = 69;

   typedef struct packed {
      logic        wr;
      logic [3:0]  mask;
      logic [31:0] addr;
      logic [31:0] wdata;
   } sreq_t;

   function automatic sreq_t sreq_pack(input logic        wr,
                                       input logic [3:0]  mask,
                                       input logic [31:0] addr,
                                       input logic [31:0] wdata);
      sreq_t r;
      r.wr    = wr;
      r.mask  = mask;
      r.addr  = addr;
      r.wdata = wdata;
      return r;
   endfunction

endpackage

// File: rtl/tawas_dbus_fifo.sv
// Synchronous request FIFO for port S. Pointers carry one extra wrap bit so
// full/empty fall out of the pointer difference.
module tawas_dbus_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 69
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   wptr, rptr;
   logic [W-1:0]  mem [DEPTH];
   logic          do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign count = wptr - rptr;
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rptr[AW-1:0]];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/tawas_dbus_arb.sv
// Data-memory port arbiter: core (port C) passes straight through with
// absolute priority; port S is queued and slotted into idle core cycles.
module tawas_dbus_arb
   import tawas_dbus_arb_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int MEM_LAT      = DBUS_MEM_LAT,
   parameter int STARVE_LIMIT = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        C_DCS,
   input  logic        C_DWR,
   input  logic [31:0] C_DADDR,
   input  logic [3:0]  C_DMASK,
   input  logic [31:0] C_DOUT,
   output logic [31:0] C_DIN,
   input  logic        S_REQ,
   output logic        S_RDY,
   input  logic        S_WR,
   input  logic [31:0] S_ADDR,
   input  logic [3:0]  S_MASK,
   input  logic [31:0] S_WDATA,
   output logic        S_RVLD,
   output logic [31:0] S_RDATA,
   output logic        S_BUSY,
   output logic        STARVE,
   output logic        M_DCS,
   output logic        M_DWR,
   output logic [31:0] M_DADDR,
   output logic [3:0]  M_DMASK,
   output logic [31:0] M_DOUT,
   input  logic [31:0] M_DIN
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int WW = $clog2(STARVE_LIMIT + 1);

   sreq_t          s_in, head;
   logic           full, empty, push, pop, rd_issue;
   logic [CW-1:0]  count;
   logic [MEM_LAT-1:0] tag_q;
   logic [MEM_LAT:0]   tag_nxt;
   logic [WW-1:0]  wcnt;

   assign s_in  = sreq_pack(S_WR, S_MASK, S_ADDR, S_WDATA);
   assign S_RDY = !full && !RST;
   assign push  = S_REQ && S_RDY;
   assign pop   = !C_DCS && !empty;
   assign C_DIN = M_DIN;

   tawas_dbus_fifo #(.DEPTH(DEPTH), .W(SREQ_W)) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push),
      .din   (s_in),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      M_DCS   = 1'b0;
      M_DWR   = 1'b0;
      M_DADDR = '0;
      M_DMASK = '0;
      M_DOUT  = '0;
      if (C_DCS) begin
         M_DCS   = 1'b1;
         M_DWR   = C_DWR;
         M_DADDR = C_DADDR;
         M_DMASK = C_DMASK;
         M_DOUT  = C_DOUT;
      end else if (!empty) begin
         M_DCS   = 1'b1;
         M_DWR   = head.wr;
         M_DADDR = head.addr;
         M_DMASK = head.mask;
         M_DOUT  = head.wdata;
      end
   end

   // Stage 0 is the issue cycle itself; stage MEM_LAT lines up with M_DIN.
   assign rd_issue = pop && !head.wr;
   assign tag_nxt  = {tag_q, rd_issue};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tag_q   <= '0;
         S_RVLD  <= 1'b0;
         S_RDATA <= '0;
      end else begin
         tag_q  <= tag_nxt[MEM_LAT-1:0];
         S_RVLD <= tag_nxt[MEM_LAT];
         if (tag_nxt[MEM_LAT]) S_RDATA <= M_DIN;
      end
   end

   assign S_BUSY = !empty || (|tag_q);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         wcnt <= '0;
      else if (empty || pop)
         wcnt <= '0;
      else if (C_DCS && wcnt != WW'(STARVE_LIMIT))
         wcnt <= wcnt + 1'b1;
   end

   assign STARVE = (wcnt == WW'(STARVE_LIMIT));

endmodule
